// File: rtl/ysyx_23060201_lsu_pkg.sv
// rtl/ysyx_23060201_lsu_pkg.sv - shared LSU encodings: FSM states, mask size codes, sign bit
// Optional misalignment check is enabled by YSYX_23060201_LSU_MISALIGN_CHK_EN.
package ysyx_23060201_lsu_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam logic [3:0] MASK_B = 4'b0001;
  localparam logic [3:0] MASK_H = 4'b0011;
  localparam logic [3:0] MASK_W = 4'b1111;

  localparam int SIGN_BIT = 4;

  // A half must sit on an even byte, a word on a word boundary.
  function automatic logic is_misaligned(input logic [1:0] off, input logic [3:0] size);
    return ((size == MASK_H) && off[0]) || ((size == MASK_W) && (off != 2'd0));
  endfunction

endpackage

// File: rtl/ysyx_23060201_lsu_if.sv
// rtl/ysyx_23060201_lsu_if.sv - word-aligned valid/ready data bus between the LSU and memory
interface ysyx_23060201_lsu_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) ();

  logic                    bus_req_valid;
  logic                    bus_req_ready;
  logic [ADDR_WIDTH-1:0]   bus_addr;
  logic                    bus_wen;
  logic [DATA_WIDTH-1:0]   bus_wdata;
  logic [DATA_WIDTH/8-1:0] bus_wstrb;
  logic                    bus_resp_valid;
  logic [DATA_WIDTH-1:0]   bus_resp_rdata;
  logic                    bus_resp_err;

  modport master (
    output bus_req_valid, bus_addr, bus_wen, bus_wdata, bus_wstrb,
    input  bus_req_ready, bus_resp_valid, bus_resp_rdata, bus_resp_err
  );

  modport slave (
    input  bus_req_valid, bus_addr, bus_wen, bus_wdata, bus_wstrb,
    output bus_req_ready, bus_resp_valid, bus_resp_rdata, bus_resp_err
  );

endinterface

// File: rtl/ysyx_23060201_lsu_align.sv
// rtl/ysyx_23060201_lsu_align.sv - byte-lane alignment for stores and extraction/extension for loads
module ysyx_23060201_lsu_align
  import ysyx_23060201_lsu_pkg::*;
(
  input  logic [1:0]  off,
  input  logic [3:0]  size,
  input  logic        sign,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata_sh,
  output logic [31:0] rdata_ext
);

  logic [31:0] rdata_sh;

  // Lanes shifted past byte 3 fall off the top; reads zero-fill from the top.
  assign wstrb    = size << off;
  assign wdata_sh = wdata << {off, 3'b000};
  assign rdata_sh = rdata >> {off, 3'b000};

  always_comb begin
    rdata_ext = 32'd0;
    case (size)
      MASK_B:  rdata_ext = {{24{sign & rdata_sh[7]}}, rdata_sh[7:0]};
      MASK_H:  rdata_ext = {{16{sign & rdata_sh[15]}}, rdata_sh[15:0]};
      MASK_W:  rdata_ext = rdata_sh;
      default: rdata_ext = 32'd0;
    endcase
  end

endmodule

// File: rtl/ysyx_23060201_lsu.sv
// rtl/ysyx_23060201_lsu.sv - multi-cycle load/store unit: one request in flight over a valid/ready bus
// Optional misaligned-access rejection: define YSYX_23060201_LSU_MISALIGN_CHK_EN.
module ysyx_23060201_lsu
  import ysyx_23060201_lsu_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,

  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  mem_ren,
  input  logic [ADDR_WIDTH-1:0] mem_raddr,
  input  logic [7:0]            mem_rmask,
  input  logic                  mem_wen,
  input  logic [ADDR_WIDTH-1:0] mem_waddr,
  input  logic [7:0]            mem_wmask,
  input  logic [DATA_WIDTH-1:0] mem_wdata,

  ysyx_23060201_lsu_if.master   bus,

  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_rdata,
  output logic                  out_err
);

  logic [1:0]            state;
  logic [1:0]            lat_off;
  logic [3:0]            lat_size;
  logic                  lat_sign;
  logic                  lat_load;

  logic [ADDR_WIDTH-1:0] req_addr;
  logic [3:0]            req_size;
  logic                  misalign;

  logic [1:0]            al_off;
  logic [3:0]            al_size;
  logic [3:0]            al_wstrb;
  logic [31:0]           al_wdata;
  logic [31:0]           al_rdata;

  logic                  unused_ok;

  assign unused_ok = ^{mem_rmask[7:5], mem_wmask[7:4]};

  assign in_ready = (state == ST_IDLE);

  assign req_addr = mem_wen ? mem_waddr : mem_raddr;
  assign req_size = mem_wen ? mem_wmask[3:0] : mem_rmask[3:0];

`ifdef YSYX_23060201_LSU_MISALIGN_CHK_EN
  assign misalign = is_misaligned(req_addr[1:0], req_size);
`else
  assign misalign = 1'b0;
`endif

  // The aligner sees the incoming request while idle and the latched one afterwards.
  assign al_off  = (state == ST_IDLE) ? req_addr[1:0] : lat_off;
  assign al_size = (state == ST_IDLE) ? req_size      : lat_size;

  ysyx_23060201_lsu_align u_align (
    .off       (al_off),
    .size      (al_size),
    .sign      (lat_sign),
    .wdata     (mem_wdata),
    .rdata     (bus.bus_resp_rdata),
    .wstrb     (al_wstrb),
    .wdata_sh  (al_wdata),
    .rdata_ext (al_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= ST_IDLE;
      lat_off           <= 2'd0;
      lat_size          <= 4'd0;
      lat_sign          <= 1'b0;
      lat_load          <= 1'b0;
      bus.bus_req_valid <= 1'b0;
      bus.bus_addr      <= '0;
      bus.bus_wen       <= 1'b0;
      bus.bus_wdata     <= '0;
      bus.bus_wstrb     <= '0;
      out_valid         <= 1'b0;
      out_rdata         <= '0;
      out_err           <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            lat_off  <= req_addr[1:0];
            lat_size <= req_size;
            lat_sign <= mem_rmask[SIGN_BIT];
            lat_load <= mem_ren & ~mem_wen;
            if (mem_ren && mem_wen) begin
              state     <= ST_DONE;
              out_valid <= 1'b1;
              out_rdata <= '0;
              out_err   <= 1'b1;
            end else if (!mem_ren && !mem_wen) begin
              state     <= ST_DONE;
              out_valid <= 1'b1;
              out_rdata <= '0;
              out_err   <= 1'b0;
            end else if (misalign) begin
              state     <= ST_DONE;
              out_valid <= 1'b1;
              out_rdata <= '0;
              out_err   <= 1'b1;
            end else begin
              state             <= ST_REQ;
              bus.bus_req_valid <= 1'b1;
              bus.bus_addr      <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
              bus.bus_wen       <= mem_wen;
              bus.bus_wdata     <= mem_wen ? al_wdata : 32'd0;
              bus.bus_wstrb     <= mem_wen ? al_wstrb : 4'd0;
            end
          end
        end
        ST_REQ: begin
          if (bus.bus_req_ready) begin
            state             <= ST_RESP;
            bus.bus_req_valid <= 1'b0;
          end
        end
        ST_RESP: begin
          if (bus.bus_resp_valid) begin
            state     <= ST_DONE;
            out_valid <= 1'b1;
            out_rdata <= lat_load ? al_rdata : 32'd0;
            out_err   <= bus.bus_resp_err;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
